// File: rtl/basic_dro_bank.sv
// Bank of independent destructive-readout (DRO) cells driven by toggle-encoded pulses.
// Each channel stores up to DEPTH pulses and replays one per read after a fixed delay.
module basic_dro_bank #(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 1,
    parameter int DELAY    = 2,
    parameter int HOLD     = 1,
    parameter int ARM      = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] set,
    input  logic [CHANNELS-1:0] read,
    input  logic                vclear,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] occupied,
    output logic [CHANNELS-1:0] violation
);

    localparam int CW = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1;
    localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam int AW = (ARM > 0) ? $clog2(ARM + 1) : 1;
    localparam int DW = (DELAY > 1) ? DELAY - 1 : 1;

    logic [AW-1:0] arm_q;
    logic          armed;

    assign armed = (arm_q == '0);

    // Only state shared between channels: input pulses are discarded until this expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_q <= AW'(ARM);
        end else if (!armed) begin
            arm_q <= arm_q - 1'b1;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : gen_ch
        logic          setPrev_q, readPrev_q;
        logic [CW-1:0] count_q, count_d;
        logic [HW-1:0] setHold_q, setHold_d;
        logic [HW-1:0] readHold_q, readHold_d;
        logic [DW-1:0] delay_q, delay_d;
        logic          out_q, out_d;
        logic          viol_q, viol_d;
        logic          setPulse, readPulse, inject, tap, newViol;

        always_comb begin
            setPulse  = armed & (set[ch] ^ setPrev_q);
            readPulse = armed & (read[ch] ^ readPrev_q);
            count_d   = count_q;
            inject    = 1'b0;
            newViol   = 1'b0;

            if (setPulse && readPulse) begin
                if (count_q != '0) begin
                    inject = 1'b1;
                end else begin
                    count_d = CW'(1);
                end
                newViol = (HOLD > 0);
            end else if (setPulse) begin
                if (count_q == CW'(DEPTH)) begin
                    newViol = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else if (readPulse) begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                    inject  = 1'b1;
                end
            end

            if (HOLD > 0) begin
                if (readPulse && (setHold_q != '0)) newViol = 1'b1;
                if (setPulse && (readHold_q != '0)) newViol = 1'b1;
            end

            setHold_d  = setPulse  ? HW'(HOLD) : ((setHold_q  != '0) ? setHold_q  - 1'b1 : setHold_q);
            readHold_d = readPulse ? HW'(HOLD) : ((readHold_q != '0) ? readHold_q - 1'b1 : readHold_q);

            // Output register is the last stage, so DELAY-1 pipeline stages precede it.
            delay_d = DW'({delay_q, inject});
            tap     = (DELAY == 1) ? inject : delay_q[DW-1];
            out_d   = out_q ^ tap;
            viol_d  = (viol_q & ~vclear) | newViol;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                setPrev_q  <= 1'b0;
                readPrev_q <= 1'b0;
                count_q    <= '0;
                setHold_q  <= '0;
                readHold_q <= '0;
                delay_q    <= '0;
                out_q      <= 1'b0;
                viol_q     <= 1'b0;
            end else begin
                setPrev_q  <= set[ch];
                readPrev_q <= read[ch];
                count_q    <= count_d;
                setHold_q  <= setHold_d;
                readHold_q <= readHold_d;
                delay_q    <= delay_d;
                out_q      <= out_d;
                viol_q     <= viol_d;
            end
        end

        assign out[ch]       = out_q;
        assign occupied[ch]  = (count_q != '0);
        assign violation[ch] = viol_q;
    end

endmodule

// File: tb/tb_basic_dro_bank.sv
// Directed self-checking bench for basic_dro_bank: default instance plus a DEPTH=3 instance.
module tb_basic_dro_bank;

    logic       clk;
    logic       rst;
    logic [3:0] set, read;
    logic       vclear;
    logic [3:0] out, occupied, violation;

    logic [3:0] set3, read3;
    logic       vclear3;
    logic [3:0] out3, occ3, viol3;

    int passed;
    int total;

    basic_dro_bank #(.CHANNELS(4), .DEPTH(1), .DELAY(2), .HOLD(1), .ARM(2)) dut (
        .clk(clk), .rst(rst), .set(set), .read(read), .vclear(vclear),
        .out(out), .occupied(occupied), .violation(violation)
    );

    basic_dro_bank #(.CHANNELS(4), .DEPTH(3), .DELAY(2), .HOLD(1), .ARM(2)) dut3 (
        .clk(clk), .rst(rst), .set(set3), .read(read3), .vclear(vclear3),
        .out(out3), .occupied(occ3), .violation(viol3)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cycle(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        set = '0; read = '0; vclear = 1'b0;
        set3 = '0; read3 = '0; vclear3 = 1'b0;
        cycle(2);
        rst = 1'b0;
        cycle(2);
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        total++;
        if ({out, occupied, violation} !== 12'h000) $display("[TB] FAIL reset_async got %h exp 000", {out, occupied, violation});
        else passed++;
        total++;
        if ({out3, occ3, viol3} !== 12'h000) $display("[TB] FAIL reset_async_d3 got %h exp 000", {out3, occ3, viol3});
        else passed++;
        doReset();
        total++;
        if ({out, occupied, violation} !== 12'h000) $display("[TB] FAIL reset_release got %h exp 000", {out, occupied, violation});
        else passed++;
    endtask

    task automatic test_basic();
        set[0] = ~set[0];
        cycle();
        total++;
        if (occupied[0] !== 1'b1) $display("[TB] FAIL basic_occ_set got %b exp 1", occupied[0]);
        else passed++;
        cycle(3);
        total++;
        if (occupied[0] !== 1'b1) $display("[TB] FAIL basic_occ_hold got %b exp 1", occupied[0]);
        else passed++;
        read[0] = ~read[0];
        cycle();
        total++;
        if ({out[0], occupied[0]} !== 2'b00) $display("[TB] FAIL basic_read_edge got %b exp 00", {out[0], occupied[0]});
        else passed++;
        cycle();
        total++;
        if (out[0] !== 1'b1) $display("[TB] FAIL basic_out_toggle got %b exp 1", out[0]);
        else passed++;
        total++;
        if (violation[0] !== 1'b0) $display("[TB] FAIL basic_no_viol got %b exp 0", violation[0]);
        else passed++;
    endtask

    task automatic test_empty_overflow();
        read[1] = ~read[1];
        cycle(4);
        total++;
        if ({out[1], occupied[1], violation[1]} !== 3'b000) $display("[TB] FAIL empty_read got %b exp 000", {out[1], occupied[1], violation[1]});
        else passed++;
        set[1] = ~set[1];
        cycle(2);
        set[1] = ~set[1];
        cycle();
        total++;
        if ({occupied[1], violation[1]} !== 2'b11) $display("[TB] FAIL overflow got %b exp 11", {occupied[1], violation[1]});
        else passed++;
        cycle();
        read[1] = ~read[1];
        cycle(2);
        total++;
        if ({out[1], occupied[1]} !== 2'b10) $display("[TB] FAIL overflow_read got %b exp 10", {out[1], occupied[1]});
        else passed++;
        cycle(3);
        total++;
        if (out[1] !== 1'b1) $display("[TB] FAIL overflow_single_toggle got %b exp 1", out[1]);
        else passed++;
    endtask

    task automatic test_hold();
        set[2] = ~set[2];
        cycle();
        read[2] = ~read[2];
        cycle();
        total++;
        if ({violation[2], occupied[2], out[2]} !== 3'b100) $display("[TB] FAIL hold_viol got %b exp 100", {violation[2], occupied[2], out[2]});
        else passed++;
        cycle();
        total++;
        if (out[2] !== 1'b1) $display("[TB] FAIL hold_out got %b exp 1", out[2]);
        else passed++;
        cycle(2);
        vclear = 1'b1;
        cycle();
        vclear = 1'b0;
        total++;
        if (violation !== 4'b0000) $display("[TB] FAIL vclear got %b exp 0000", violation);
        else passed++;

        // Simultaneous set+read on an empty channel while clearing: new flag must survive.
        set[2] = ~set[2];
        read[2] = ~read[2];
        vclear = 1'b1;
        cycle();
        vclear = 1'b0;
        total++;
        if ({violation, occupied[2]} !== 5'b0100_1) $display("[TB] FAIL simul_empty got %b exp 01001", {violation, occupied[2]});
        else passed++;
        cycle(2);
        set[2] = ~set[2];
        read[2] = ~read[2];
        cycle();
        total++;
        if ({occupied[2], out[2]} !== 2'b11) $display("[TB] FAIL simul_full_edge got %b exp 11", {occupied[2], out[2]});
        else passed++;
        cycle();
        total++;
        if (out[2] !== 1'b0) $display("[TB] FAIL simul_full_out got %b exp 0", out[2]);
        else passed++;
        cycle();
        read[2] = ~read[2];
        cycle(2);
        total++;
        if ({occupied, out} !== 8'b0000_0111) $display("[TB] FAIL channel_state got %b exp 00000111", {occupied, out});
        else passed++;
    endtask

    task automatic test_depth3();
        for (int k = 0; k < 3; k++) begin
            set3[0] = ~set3[0];
            cycle();
            total++;
            if (occ3[0] !== 1'b1) $display("[TB] FAIL d3_set%0d got %b exp 1", k, occ3[0]);
            else passed++;
            cycle(3);
        end
        for (int k = 0; k < 3; k++) begin
            read3[0] = ~read3[0];
            cycle(2);
            total++;
            if (out3[0] !== ((k % 2 == 0) ? 1'b1 : 1'b0)) $display("[TB] FAIL d3_read%0d_out got %b exp %b", k, out3[0], (k % 2 == 0) ? 1'b1 : 1'b0);
            else passed++;
            total++;
            if (occ3[0] !== ((k < 2) ? 1'b1 : 1'b0)) $display("[TB] FAIL d3_read%0d_occ got %b exp %b", k, occ3[0], (k < 2) ? 1'b1 : 1'b0);
            else passed++;
            cycle(2);
        end
        total++;
        if (viol3 !== 4'b0000) $display("[TB] FAIL d3_viol got %b exp 0000", viol3);
        else passed++;
    endtask

    task automatic test_arm();
        rst = 1'b1;
        set = '0; read = '0; vclear = 1'b0;
        cycle(2);
        rst = 1'b0;
        set[3] = 1'b1;
        cycle();
        set[2] = 1'b1;
        cycle();
        set[1] = 1'b1;
        cycle();
        total++;
        if (occupied !== 4'b0010) $display("[TB] FAIL arm_window got %b exp 0010", occupied);
        else passed++;
        read[3] = 1'b1;
        cycle(4);
        total++;
        if ({out[3], occupied[3], violation[3]} !== 3'b000) $display("[TB] FAIL arm_read got %b exp 000", {out[3], occupied[3], violation[3]});
        else passed++;
    endtask

    task automatic test_reset_midflight();
        doReset();
        set[0] = ~set[0];
        cycle(2);
        read[0] = ~read[0];
        cycle();
        rst = 1'b1;
        #1;
        total++;
        if ({out, occupied, violation} !== 12'h000) $display("[TB] FAIL midflight_async got %h exp 000", {out, occupied, violation});
        else passed++;
        cycle();
        rst = 1'b0;
        cycle(4);
        total++;
        if ({out, occupied, violation} !== 12'h000) $display("[TB] FAIL midflight_after got %h exp 000", {out, occupied, violation});
        else passed++;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        set = '0; read = '0; vclear = 1'b0;
        set3 = '0; read3 = '0; vclear3 = 1'b0;
        passed = 0;
        total = 0;
        test_reset();
        test_basic();
        test_empty_overflow();
        test_hold();
        test_depth3();
        test_arm();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
